// File: rtl/hilo_mdu_ctrl_if.sv
// EX-stage <-> multiply/divide sequencer bundle: op request, operands, current HI/LO,
// flush, and the stall / HI-LO write-back outputs.
interface hilo_mdu_ctrl_if;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic [31:0] hi_cur_i;
  logic [31:0] lo_cur_i;
  logic        flush_i;
  logic        stall_o;
  logic        hilowe_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy_o;

  modport master (
    output start_i, op_i, src_a_i, src_b_i, hi_cur_i, lo_cur_i, flush_i,
    input  stall_o, hilowe_o, hi_o, lo_o, busy_o
  );

  modport slave (
    input  start_i, op_i, src_a_i, src_b_i, hi_cur_i, lo_cur_i, flush_i,
    output stall_o, hilowe_o, hi_o, lo_o, busy_o
  );
endinterface

// File: rtl/hilo_mdu_ctrl.sv
// HI/LO owner: sequences MULT/MULTU (fixed latency), DIV/DIVU (restoring radix-2)
// and MTHI/MTLO, stalling the pipe while busy and pulsing one HI/LO write.
module hilo_mdu_ctrl #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_ITERS  = 32
) (
  input logic          cpu_clk_50M,
  input logic          cpu_rst_n,
  hilo_mdu_ctrl_if.slave mdu
);
  localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_WB = 2'd3;
  localparam logic [2:0] OP_MULT = 3'b001, OP_MULTU = 3'b010, OP_DIV = 3'b011,
                         OP_DIVU = 3'b100, OP_MTHI = 3'b101, OP_MTLO = 3'b110;

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic [63:0] prod_q;
  logic [31:0] rem_q, quo_q, dvs_q, hi_q, lo_q;
  logic        neg_q, neg_r;

  logic is_mul, is_div, is_mt, accept;
  assign is_mul = (mdu.op_i == OP_MULT) || (mdu.op_i == OP_MULTU);
  assign is_div = (mdu.op_i == OP_DIV)  || (mdu.op_i == OP_DIVU);
  assign is_mt  = (mdu.op_i == OP_MTHI) || (mdu.op_i == OP_MTLO);
  assign accept = (state == S_IDLE) && mdu.start_i && !mdu.flush_i && (is_mul || is_div || is_mt);

  // 33-bit operands let one signed multiplier serve both MULT and MULTU
  logic               sgn_mul;
  logic signed [32:0] mul_a, mul_b;
  logic signed [65:0] prod_full;
  assign sgn_mul   = (mdu.op_i == OP_MULT);
  assign mul_a     = {sgn_mul & mdu.src_a_i[31], mdu.src_a_i};
  assign mul_b     = {sgn_mul & mdu.src_b_i[31], mdu.src_b_i};
  assign prod_full = mul_a * mul_b;

  // Magnitudes: negating 0x80000000 in 32 bits yields 0x80000000, the correct unsigned value
  logic        a_sgn, b_sgn;
  logic [31:0] a_mag, b_mag;
  assign a_sgn = (mdu.op_i == OP_DIV) && mdu.src_a_i[31];
  assign b_sgn = (mdu.op_i == OP_DIV) && mdu.src_b_i[31];
  assign a_mag = a_sgn ? (~mdu.src_a_i + 32'd1) : mdu.src_a_i;
  assign b_mag = b_sgn ? (~mdu.src_b_i + 32'd1) : mdu.src_b_i;

  logic [32:0] div_shl, div_diff;
  logic        div_ge;
  logic [31:0] rem_nx, quo_nx;
  assign div_shl  = {rem_q, quo_q[31]};
  assign div_diff = div_shl - {1'b0, dvs_q};
  assign div_ge   = (div_shl >= {1'b0, dvs_q});
  assign rem_nx   = div_ge ? div_diff[31:0] : div_shl[31:0];
  assign quo_nx   = {quo_q[30:0], div_ge};

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      prod_q <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          cnt <= '0;
          if (is_mt) begin
            state <= S_WB;
            hi_q  <= (mdu.op_i == OP_MTHI) ? mdu.src_a_i : mdu.hi_cur_i;
            lo_q  <= (mdu.op_i == OP_MTLO) ? mdu.src_a_i : mdu.lo_cur_i;
          end else if (is_mul) begin
            state  <= S_MUL;
            prod_q <= prod_full[63:0];
          end else if (mdu.src_b_i == 32'd0) begin
            state <= S_WB;
            hi_q  <= mdu.src_a_i;
            lo_q  <= 32'hFFFF_FFFF;
          end else begin
            state <= S_DIV;
            rem_q <= '0;
            quo_q <= a_mag;
            dvs_q <= b_mag;
            neg_q <= a_sgn ^ b_sgn;
            neg_r <= a_sgn;
          end
        end
        S_MUL: begin
          if (mdu.flush_i) state <= S_IDLE;
          else if (cnt == 6'(MUL_CYCLES - 1)) begin
            state <= S_WB;
            hi_q  <= prod_q[63:32];
            lo_q  <= prod_q[31:0];
          end else cnt <= cnt + 6'd1;
        end
        S_DIV: begin
          if (mdu.flush_i) state <= S_IDLE;
          else begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            if (cnt == 6'(DIV_ITERS - 1)) begin
              state <= S_WB;
              hi_q  <= neg_r ? (~rem_nx + 32'd1) : rem_nx;
              lo_q  <= neg_q ? (~quo_nx + 32'd1) : quo_nx;
            end else cnt <= cnt + 6'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stall drops in WB so the stalled instruction advances as HI/LO captures
  assign mdu.stall_o  = !mdu.flush_i &&
                        ((state == S_MUL) || (state == S_DIV) || (accept && (is_mul || is_div)));
  assign mdu.hilowe_o = (state == S_WB) && !mdu.flush_i;
  assign mdu.busy_o   = (state != S_IDLE);
  assign mdu.hi_o     = hi_q;
  assign mdu.lo_o     = lo_q;
endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Directed checks of hilo_mdu_ctrl: latencies, results, stall shape, flush and async reset.
module tb_hilo_mdu_ctrl;
  logic clk;
  logic rst_n;
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   total    = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  hilo_mdu_ctrl_if bus();

  hilo_mdu_ctrl #(.MUL_CYCLES(2), .DIV_ITERS(32)) dut (
    .cpu_clk_50M (clk),
    .cpu_rst_n   (rst_n),
    .mdu         (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Issue one op, then follow it to its write-back cycle; returns at the WB negedge.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, b, hc, lc,
                        input int lat, input logic stl, input logic [31:0] eh, el);
    int   n;
    logic stall_ok;
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.op_i = op; bus.src_a_i = a; bus.src_b_i = b;
    bus.hi_cur_i = hc; bus.lo_cur_i = lc;
    @(negedge clk);
    chk({tag, "_acc_stall"}, 32'(bus.stall_o), 32'(stl));
    chk({tag, "_acc_we"}, 32'(bus.hilowe_o), 32'd0);
    chk({tag, "_acc_busy"}, 32'(bus.busy_o), 32'd0);
    chk({tag, "_hold_hi"}, bus.hi_o, last_hi);
    chk({tag, "_hold_lo"}, bus.lo_o, last_lo);
    @(posedge clk); #1;
    // Scramble inputs after accept so results must come from sampled values
    bus.start_i = 1'b0; bus.op_i = 3'b000; bus.src_a_i = 32'hDEAD_BEEF; bus.src_b_i = 32'hCAFE_F00D;
    bus.hi_cur_i = 32'h5A5A_5A5A; bus.lo_cur_i = 32'hA5A5_A5A5;
    n = 1; stall_ok = 1'b1;
    @(negedge clk);
    while (!bus.hilowe_o && n < 60) begin
      if (bus.stall_o !== stl) stall_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    chk({tag, "_busy_stall"}, 32'(stall_ok), 32'd1);
    chk({tag, "_wb_stall"}, 32'(bus.stall_o), 32'd0);
    chk({tag, "_hi"}, bus.hi_o, eh);
    chk({tag, "_lo"}, bus.lo_o, el);
    last_hi = eh; last_lo = el;
  endtask

  initial begin
    int bad;
    bus.start_i = 1'b0; bus.op_i = 3'b000; bus.src_a_i = '0; bus.src_b_i = '0;
    bus.hi_cur_i = '0; bus.lo_cur_i = '0; bus.flush_i = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("rst_stall", 32'(bus.stall_o), 32'd0);
    chk("rst_we", 32'(bus.hilowe_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_hi", bus.hi_o, 32'd0);
    chk("rst_lo", bus.lo_o, 32'd0);
    #21 rst_n = 1'b1;

    run_op("mult",   3'b001, 32'hFFFF_FFFF, 32'd2, 0, 0, 3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu",  3'b010, 32'hFFFF_FFFF, 32'd2, 0, 0, 3, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div_n7", 3'b011, 32'hFFFF_FFF9, 32'd2, 0, 0, 33, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7n", 3'b011, 32'd7, 32'hFFFF_FFFE, 0, 0, 33, 1'b1, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("div_nn", 3'b011, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 0, 0, 33, 1'b1, 32'hFFFF_FFFF, 32'h0000_0003);
    run_op("divu",   3'b100, 32'd100, 32'd7, 0, 0, 33, 1'b1, 32'h0000_0002, 32'h0000_000E);
    run_op("div_ov", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 33, 1'b1, 32'h0, 32'h8000_0000);
    run_op("div0",   3'b100, 32'h1234, 32'd0, 0, 0, 1, 1'b1, 32'h0000_1234, 32'hFFFF_FFFF);
    run_op("mthi",   3'b101, 32'h1234, 0, 32'h7777, 32'hABCD, 1, 1'b0, 32'h0000_1234, 32'h0000_ABCD);
    run_op("mtlo",   3'b110, 32'h5678, 0, 32'h9999, 32'h1111, 1, 1'b0, 32'h0000_9999, 32'h0000_5678);

    // op 111 is not an operation and must be ignored
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.op_i = 3'b111;
    @(negedge clk);
    chk("op7_stall", 32'(bus.stall_o), 32'd0);
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    @(negedge clk);
    chk("op7_busy", 32'(bus.busy_o), 32'd0);
    chk("op7_we", 32'(bus.hilowe_o), 32'd0);

    // Flush mid-divide, with an ignored start while busy
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.op_i = 3'b100; bus.src_a_i = 32'd1000; bus.src_b_i = 32'd3;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    bus.start_i = 1'b1; bus.op_i = 3'b101; bus.src_a_i = 32'hBAD0_0001;
    @(negedge clk);
    chk("fl_busy_stall", 32'(bus.stall_o), 32'd1);
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    @(negedge clk);
    chk("fl_ignored_start", 32'(bus.hilowe_o), 32'd0);
    repeat (4) begin @(posedge clk); #1; end
    bus.flush_i = 1'b1;
    @(negedge clk);
    chk("fl_stall", 32'(bus.stall_o), 32'd0);
    chk("fl_we", 32'(bus.hilowe_o), 32'd0);
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    @(negedge clk);
    chk("fl_idle", 32'(bus.busy_o), 32'd0);
    chk("fl_idle_stall", 32'(bus.stall_o), 32'd0);
    bad = 0;
    repeat (40) begin @(negedge clk); if (bus.hilowe_o !== 1'b0) bad++; end
    chk("fl_no_write", 32'(bad), 32'd0);
    chk("fl_hi_kept", bus.hi_o, last_hi);

    // start together with flush in IDLE
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.op_i = 3'b001; bus.flush_i = 1'b1;
    @(negedge clk);
    chk("sf_stall", 32'(bus.stall_o), 32'd0);
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.flush_i = 1'b0;
    @(negedge clk);
    chk("sf_busy", 32'(bus.busy_o), 32'd0);
    bad = 0;
    repeat (5) begin @(negedge clk); if (bus.hilowe_o !== 1'b0) bad++; end
    chk("sf_no_write", 32'(bad), 32'd0);

    // Async reset mid-divide
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.op_i = 3'b100; bus.src_a_i = 32'd50; bus.src_b_i = 32'd5;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_busy", 32'(bus.busy_o), 32'd0);
    chk("ar_stall", 32'(bus.stall_o), 32'd0);
    chk("ar_we", 32'(bus.hilowe_o), 32'd0);
    chk("ar_hi", bus.hi_o, 32'd0);
    chk("ar_lo", bus.lo_o, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    bad = 0;
    repeat (40) begin @(negedge clk); if (bus.hilowe_o !== 1'b0 || bus.busy_o !== 1'b0) bad++; end
    chk("ar_no_write", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
